i2c_regwr_master: RTL and testbench

Single-master I2C write initiator for the board-level control path. It accepts one register write request (register address byte plus data byte) on a valid/ready handshake and drives a complete I2C write transaction on open-drain SCL/SDA enables: START, device address with W, register byte, data byte, STOP. It is the initiator counterpart of the on-chip I2C register slave. It runs in the clk1d domain and lets the design and its bench program PWM compare and delta-sigma registers over the same bus.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_qtick.sv | 46 ++++
 rtl/i2c_regwr_master.sv | 168 ++++++++++++++++
 tb/tb_i2c_regwr_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for the register-write master and the register slave
// Contents: i2c_state_t (transaction FSM states), i2c_quarter_t (SCL quarter index),
//           I2C_WR (R/W bit value for a write), i2c_addr_byte() (address byte builder).
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } i2c_state_t;

  typedef logic [1:0] i2c_quarter_t;

  localparam logic I2C_WR = 1'b0;

  function automatic logic [7:0] i2c_addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - SCL quarter-period tick generator with stretch hold
// Ports: clk1d/rst   clock, asynchronous active-high reset
//        run         count while high; counter and index are cleared while low
//        clr         restart at quarter 0 (takes effect on the next cycle)
//        hold        keep the current quarter open past its QDIV minimum
//        qtick       one-cycle pulse on the last cycle of a quarter
//        qidx        index of the current quarter (0..3)
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int QDIV = 5
) (
  input  logic         clk1d,
  input  logic         rst,
  input  logic         run,
  input  logic         clr,
  input  logic         hold,
  output logic         qtick,
  output i2c_quarter_t qidx
);

  localparam int CW = $clog2(QDIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  // The counter saturates at CNT_LAST while hold is high, so a stretched
  // quarter ends on the first cycle hold drops once the minimum has elapsed.
  assign qtick = run && (cnt == CNT_LAST) && !hold;

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      qidx <= '0;
    end else if (!run || clr) begin
      cnt  <= '0;
      qidx <= '0;
    end else if (qtick) begin
      cnt  <= '0;
      qidx <= i2c_quarter_t'(qidx + 2'd1);
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_regwr_master.sv
// rtl/i2c_regwr_master.sv - single-master I2C write initiator: START, {DEV_ADDR,W}, reg byte, data byte, STOP
// Ports: clk1d/rst            clock, asynchronous active-high reset
//        req_valid/req_ready  request handshake; req_addr/req_data latched on accept
//        busy                 transaction in progress (including the DONE cycle)
//        done                 one-cycle pulse at transaction end
//        nack/timeout         status of the last transaction, held until the next accept
//        scl_oe/sda_oe        1 = pull the line low (open drain)
//        scl_in/sda_in        already-synchronized line levels
module i2c_regwr_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         QDIV        = 5,
  parameter int         STRETCH_MAX = 1023
) (
  input  logic       clk1d,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout,
  output logic       scl_oe,
  input  logic       scl_in,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int SW = $clog2(STRETCH_MAX + 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_MAX - 1);

  i2c_state_t   state, state_nx;
  i2c_quarter_t qidx;
  logic         qtick;
  logic [7:0]   shreg;
  logic [7:0]   addr_q;
  logic [7:0]   data_q;
  logic [3:0]   bit_cnt;
  logic [1:0]   byte_cnt;
  logic [SW-1:0] stretch_cnt;

  logic run, qclr, q_last, q2_wait, hold, stretch_to;

  assign run        = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);
  // START has only two quarters; restart the index so BIT begins at Q0.
  assign qclr       = (state == START) && qtick && (qidx == 2'd1);
  assign q_last     = qtick && (qidx == 2'd3);
  // Q2 of a clocked phase: SCL is released and must be seen high before Q3.
  assign q2_wait    = ((state == BIT) || (state == ACK) || (state == STOP)) && (qidx == 2'd2);
  assign hold       = q2_wait && !scl_in;
  assign stretch_to = hold && (stretch_cnt == STRETCH_LAST);

  i2c_qtick #(
    .QDIV(QDIV)
  ) u_qtick (
    .clk1d(clk1d),
    .rst  (rst),
    .run  (run),
    .clr  (qclr),
    .hold (hold),
    .qtick(qtick),
    .qidx (qidx)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Line drives are decoded straight from state so an asynchronous reset
  // releases both lines in the same cycle.
  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nx = START;
      end
      START: begin
        sda_oe = (qidx == 2'd1);
        if (qclr) state_nx = BIT;
      end
      BIT: begin
        scl_oe = !qidx[1];
        sda_oe = !shreg[7];
        if (stretch_to)                         state_nx = DONE;
        else if (q_last && (bit_cnt == 4'd7))   state_nx = ACK;
      end
      ACK: begin
        scl_oe = !qidx[1];
        if (stretch_to) begin
          state_nx = DONE;
        end else if (q_last) begin
          if (sda_in || (byte_cnt == 2'd2)) state_nx = STOP;
          else                              state_nx = BIT;
        end
      end
      STOP: begin
        scl_oe = !qidx[1];
        sda_oe = (qidx != 2'd3);
        if (stretch_to || q_last) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      stretch_cnt <= '0;
      nack        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (!q2_wait || qtick) stretch_cnt <= '0;
      else if (!scl_in)      stretch_cnt <= stretch_cnt + 1'b1;

      if (stretch_to) timeout <= 1'b1;

      case (state)
        IDLE: begin
          if (req_valid) begin
            shreg    <= i2c_addr_byte(DEV_ADDR, I2C_WR);
            addr_q   <= req_addr;
            data_q   <= req_data;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            nack     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        BIT: begin
          if (q_last) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ACK: begin
          if (q_last) begin
            bit_cnt  <= '0;
            byte_cnt <= byte_cnt + 1'b1;
            nack     <= sda_in;
            shreg    <= (byte_cnt == 2'd0) ? addr_q : data_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_regwr_master.sv
// tb/tb_i2c_regwr_master.sv - directed bench for i2c_regwr_master with an open-drain bus monitor and ACKing slave model
module tb_i2c_regwr_master;

  localparam int QDIV        = 5;
  localparam int STRETCH_MAX = 63;

  logic       clk1d = 1'b0;
  logic       rst   = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       busy, done, nack, timeout;
  logic       scl_oe, sda_oe;
  logic       scl_in, sda_in;

  logic scl_hold = 1'b0;
  logic slv_sda  = 1'b0;
  logic ack_en   = 1'b1;

  int checks = 0;
  int errors = 0;

  assign scl_in = ~(scl_oe | scl_hold);
  assign sda_in = ~(sda_oe | slv_sda);

  always #5 clk1d = ~clk1d;

  i2c_regwr_master #(
    .DEV_ADDR   (7'h2A),
    .QDIV       (QDIV),
    .STRETCH_MAX(STRETCH_MAX)
  ) dut (
    .clk1d    (clk1d),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .timeout  (timeout),
    .scl_oe   (scl_oe),
    .scl_in   (scl_in),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in)
  );

  // Bus monitor and slave: decodes START/bits/STOP on the wired lines and
  // pulls SDA low for the ninth clock of every byte when ack_en is set.
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic [8:0] mon_sh   = '0;
  int         nbits    = 0;
  int         saw_stop = 0;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];

  always @(negedge clk1d) begin
    if (rst) begin
      slv_sda = 1'b0;
    end else if (scl_in && scl_prev && sda_prev && !sda_in) begin
      nbits    = 0;
      saw_stop = 0;
      mon_bytes.delete();
      mon_acks.delete();
    end else if (scl_in && scl_prev && !sda_prev && sda_in) begin
      saw_stop = 1;
    end else if (scl_in && !scl_prev) begin
      mon_sh = {mon_sh[7:0], sda_in};
      nbits++;
      if (nbits % 9 == 0) begin
        mon_bytes.push_back(mon_sh[8:1]);
        mon_acks.push_back(mon_sh[0]);
      end
    end else if (!scl_in && scl_prev) begin
      slv_sda = ack_en && (nbits % 9 == 8);
    end
    scl_prev = scl_in;
    sda_prev = sda_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk1d);
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && n < 2000) begin
      @(negedge clk1d);
      n++;
    end
    @(posedge clk1d);
    #1 req_valid = 1'b0;
  endtask

  // Number of clock edges from the accept edge to the edge that raises done.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin
      @(posedge clk1d);
      #1;
      n++;
    end
  endtask

  function automatic logic [7:0] mon_byte(input int k);
    return (mon_bytes.size() > k) ? mon_bytes[k] : 8'hxx;
  endfunction

  function automatic logic mon_ack(input int k);
    return (mon_acks.size() > k) ? mon_acks[k] : 1'bx;
  endfunction

  task automatic check_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_nbytes"}, mon_bytes.size(), 3);
    chk({tag, "_byte0"}, mon_byte(0), 8'h54);
    chk({tag, "_byte1"}, mon_byte(1), a);
    chk({tag, "_byte2"}, mon_byte(2), d);
    chk({tag, "_acks"}, {mon_ack(0), mon_ack(1), mon_ack(2)}, 3'b000);
    chk({tag, "_stop"}, saw_stop, 1);
  endtask

  task automatic stretch_bit(output int qlen);
    int n = 0;
    qlen = 0;
    while (nbits < 22 && n < 5000) begin @(posedge clk1d); #1; n++; end
    while (!scl_oe && n < 5000) begin @(posedge clk1d); #1; n++; end
    while (scl_oe && n < 5000) begin @(posedge clk1d); #1; n++; end
    scl_hold = 1'b1;
    qlen = 1;
    repeat (40) @(posedge clk1d);
    #1 scl_hold = 1'b0;
    qlen = 41;
    while (!scl_oe && qlen < 200) begin
      @(posedge clk1d);
      #1;
      if (!scl_oe) qlen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int qlen;

    repeat (3) @(posedge clk1d);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", {nack, timeout}, 2'b00);
    chk("rst_lines", {scl_oe, sda_oe}, 2'b00);
    @(negedge clk1d);
    rst = 1'b0;

    // Basic write, with a request presented mid-transaction that must be ignored.
    fork
      begin
        issue(8'h03, 8'h5C);
        chk("w1_busy", busy, 1);
        wait_done(n);
      end
      begin
        repeat (100) @(negedge clk1d);
        req_addr  = 8'hEE;
        req_data  = 8'hEE;
        req_valid = 1'b1;
        chk("w1_ign_ready", req_ready, 0);
        repeat (3) @(negedge clk1d);
        req_valid = 1'b0;
      end
    join
    chk("w1_cycles", n, 570);
    chk("w1_status", {nack, timeout}, 2'b00);
    check_write("w1", 8'h03, 8'h5C);
    @(posedge clk1d);
    #1;
    chk("w1_after", {req_ready, busy, done}, 3'b100);

    issue(8'hFF, 8'h00);
    wait_done(n);
    chk("w2_cycles", n, 570);
    check_write("w2", 8'hFF, 8'h00);

    // No ACK on the address byte.
    ack_en = 1'b0;
    issue(8'h11, 8'h22);
    wait_done(n);
    chk("nack_cycles", n, 210);
    chk("nack_flag", nack, 1);
    chk("nack_nbytes", mon_bytes.size(), 1);
    chk("nack_byte0", mon_byte(0), 8'h54);
    chk("nack_ack0", mon_ack(0), 1);
    chk("nack_stop", saw_stop, 1);
    @(posedge clk1d);
    #1;
    chk("nack_held", {nack, req_ready}, 2'b11);
    ack_en = 1'b1;

    // Slave stretches SCL for 40 cycles in data bit 3.
    fork
      begin
        issue(8'h01, 8'hB7);
        chk("st_nack_clr", nack, 0);
        wait_done(n);
      end
      stretch_bit(qlen);
    join
    chk("st_cycles", n, 606);
    chk("st_scl_rel_len", qlen, 46);
    chk("st_timeout", timeout, 0);
    check_write("st", 8'h01, 8'hB7);

    // SCL held low permanently: timeout after STRETCH_MAX cycles in BIT Q2.
    scl_hold = 1'b1;
    issue(8'h22, 8'h33);
    wait_done(n);
    chk("to_cycles", n, 83);
    chk("to_flag", timeout, 1);
    chk("to_lines", {scl_oe, sda_oe}, 2'b00);
    @(posedge clk1d);
    #1;
    chk("to_after", {req_ready, timeout, nack}, 3'b110);
    scl_hold = 1'b0;
    repeat (5) @(posedge clk1d);

    // Reset during the data byte (bit value 0 at pulse 22: both lines low).
    issue(8'h44, 8'h66);
    n = 0;
    while (nbits < 21 && n < 5000) begin @(posedge clk1d); #1; n++; end
    while (!scl_oe && n < 5000) begin @(posedge clk1d); #1; n++; end
    chk("rs_pre_lines", {scl_oe, sda_oe}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("rs_lines", {scl_oe, sda_oe}, 2'b00);
    chk("rs_ready", {req_ready, busy}, 2'b10);
    repeat (3) @(negedge clk1d);
    rst = 1'b0;
    @(posedge clk1d);
    #1;
    chk("rs_after", {req_ready, busy, nack, timeout}, 4'b1000);
    issue(8'h7E, 8'h81);
    wait_done(n);
    chk("rs_w_cycles", n, 570);
    check_write("rs_w", 8'h7E, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
